// File: rtl/arduino_note_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// arduino_note_sequencer_pkg
//   Shared definitions for the note sequencer: FSM state encoding, the note
//   codes understood by the Arduino-side decoder, and the one-hot-to-code
//   encoder used when a sequence word is loaded.
// ----------------------------------------------------------------------------
package arduino_note_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_PLAY  = 3'd3,
      ST_GAP   = 3'd4,
      ST_DONE  = 3'd5
   } seq_state_t;

   // Codes driven on arduino_out; bit i of a memory word maps to code i+1.
   localparam logic [2:0] NOTE_SILENCE = 3'd0;
   localparam logic [2:0] NOTE_DO      = 3'd1;
   localparam logic [2:0] NOTE_RE      = 3'd2;
   localparam logic [2:0] NOTE_MI      = 3'd3;
   localparam logic [2:0] NOTE_FA      = 3'd4;
   localparam logic [2:0] NOTE_SOL     = 3'd5;
   localparam logic [2:0] NOTE_LA      = 3'd6;
   localparam logic [2:0] NOTE_SI      = 3'd7;

   // Returns index+1 for an exactly-one-hot word, NOTE_SILENCE otherwise.
   // A silent result therefore doubles as the "bad word" indication.
   function automatic logic [2:0] onehot_to_code(input logic [6:0] onehot);
      logic [2:0] code;
      int unsigned n_set;
      code  = NOTE_SILENCE;
      n_set = 0;
      for (int i = 0; i < 7; i++) begin
         if (onehot[i]) begin
            code  = 3'(i + 1);
            n_set = n_set + 1;
         end
      end
      if (n_set != 1) begin
         code = NOTE_SILENCE;
      end
      return code;
   endfunction

endpackage

// File: rtl/arduino_note_sequencer_if.sv
// ----------------------------------------------------------------------------
// arduino_note_sequencer_if
//   Control handshake, private sequence-memory port and Arduino note bus of
//   the sequencer.
//   master : game controller / memory side (drives start, abort, limite,
//            mem_data)
//   slave  : the sequencer (drives mem_addr, arduino_out, busy, done,
//            bad_note)
// ----------------------------------------------------------------------------
interface arduino_note_sequencer_if;
   logic       start;
   logic       abort;
   logic [3:0] limite;
   logic [3:0] mem_addr;
   logic [6:0] mem_data;
   logic [2:0] arduino_out;
   logic       busy;
   logic       done;
   logic       bad_note;

   modport master (
      output start, abort, limite, mem_data,
      input  mem_addr, arduino_out, busy, done, bad_note
   );

   modport slave (
      input  start, abort, limite, mem_data,
      output mem_addr, arduino_out, busy, done, bad_note
   );
endinterface

// File: rtl/arduino_note_sequencer_note_timer.sv
// ----------------------------------------------------------------------------
// note_timer
//   Down-counter timing both the note and the gap intervals.
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one
//   zero     : count is zero
// ----------------------------------------------------------------------------
module note_timer #(
   parameter int TMR_W = 25
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [TMR_W-1:0] count_reg;
   logic [TMR_W-1:0] count_next;

   always_comb begin
      count_next = count_reg;
      if (load) begin
         count_next = load_val;
      end else if (dec) begin
         count_next = count_reg - TMR_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/arduino_note_sequencer.sv
// ----------------------------------------------------------------------------
// arduino_note_sequencer
//   Plays sequence entries 0..limite on arduino_out; every note is followed
//   by a silent gap. Reads the sequence memory through a private address
//   port (synchronous ROM, 1-cycle latency).
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of arduino_note_sequencer_if (start/abort/limite in,
//           mem_addr/mem_data memory port, arduino_out/busy/done/bad_note out)
// ----------------------------------------------------------------------------
module arduino_note_sequencer
   import arduino_note_sequencer_pkg::*;
#(
   parameter int NOTE_CYCLES = 25_000_000,
   parameter int GAP_CYCLES  = 12_500_000,
   parameter int TMR_W       = 25
) (
   input  logic                     clock,
   input  logic                     reset,
   arduino_note_sequencer_if.slave  bus
);

   seq_state_t state_reg, state_next;
   logic [3:0] mem_addr_reg, mem_addr_next;
   logic [3:0] limit_reg, limit_next;
   logic [2:0] out_reg, out_next;
   logic       busy_reg, busy_next;
   logic       done_reg, done_next;
   logic       bad_reg, bad_next;

   logic             tmr_load;
   logic             tmr_dec;
   logic [TMR_W-1:0] tmr_val;
   logic             tmr_zero;
   logic [2:0]       load_code;

   note_timer #(.TMR_W(TMR_W)) u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .dec      (tmr_dec),
      .zero     (tmr_zero)
   );

   assign load_code = onehot_to_code(bus.mem_data);

   always_comb begin
      state_next    = state_reg;
      mem_addr_next = mem_addr_reg;
      limit_next    = limit_reg;
      out_next      = out_reg;
      bad_next      = bad_reg;
      tmr_load      = 1'b0;
      tmr_dec       = 1'b0;
      tmr_val       = '0;

      if (bus.abort) begin
         // abort beats everything, including a simultaneous start
         state_next = ST_IDLE;
         out_next   = NOTE_SILENCE;
      end else begin
         unique case (state_reg)
            ST_IDLE: begin
               if (bus.start) begin
                  limit_next    = bus.limite;
                  mem_addr_next = 4'd0;
                  bad_next      = 1'b0;
                  state_next    = ST_FETCH;
               end
            end
            ST_FETCH: begin
               // address has been stable one cycle; ROM word arrives in LOAD
               state_next = ST_LOAD;
            end
            ST_LOAD: begin
               out_next = load_code;
               if (load_code == NOTE_SILENCE) begin
                  bad_next = 1'b1;
               end
               tmr_load   = 1'b1;
               tmr_val    = TMR_W'(NOTE_CYCLES - 1);
               state_next = ST_PLAY;
            end
            ST_PLAY: begin
               if (tmr_zero) begin
                  tmr_load   = 1'b1;
                  tmr_val    = TMR_W'(GAP_CYCLES - 1);
                  out_next   = NOTE_SILENCE;
                  state_next = ST_GAP;
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            ST_GAP: begin
               if (tmr_zero) begin
                  // compare before increment, so limit 15 never wraps the address
                  if (mem_addr_reg == limit_reg) begin
                     state_next = ST_DONE;
                  end else begin
                     mem_addr_next = mem_addr_reg + 4'd1;
                     state_next    = ST_FETCH;
                  end
               end else begin
                  tmr_dec = 1'b1;
               end
            end
            ST_DONE: begin
               state_next = ST_IDLE;
            end
            default: begin
               state_next = ST_IDLE;
               out_next   = NOTE_SILENCE;
            end
         endcase
      end
   end

   // busy and done are registered copies of the state being entered
   assign busy_next = (state_next != ST_IDLE);
   assign done_next = (state_next == ST_DONE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         mem_addr_reg <= 4'd0;
         limit_reg    <= 4'd0;
         out_reg      <= NOTE_SILENCE;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         bad_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         mem_addr_reg <= mem_addr_next;
         limit_reg    <= limit_next;
         out_reg      <= out_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         bad_reg      <= bad_next;
      end
   end

   assign bus.mem_addr    = mem_addr_reg;
   assign bus.arduino_out = out_reg;
   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
   assign bus.bad_note    = bad_reg;

endmodule
